mbledhesi_serik: RTL and testbench

- Parametrised multi-cycle adder/subtractor for the CPU datapath.
- Processes a WIDTH-bit operand pair SLICE bits per clock using a registered ripple carry, trading latency for area.
- START/BUSY/DONE handshake toward the ALU controller.
- Produces sum plus carry, signed-overflow and zero flags.

---
 rtl/mbledhesi_serik_if.sv | 27 ++
 rtl/mbledhesi_serik.sv | 146 ++++++++++++++
 tb/tb_mbledhesi_serik.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mbledhesi_serik_if.sv
// Handshake and operand/result bundle between the ALU controller and the
// multi-cycle adder/subtractor mbledhesi_serik.
interface mbledhesi_serik_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             v;
  logic             z;

  modport master (
    output start, op, a, b, cin,
    input  busy, done, s, cout, v, z
  );

  modport slave (
    input  start, op, a, b, cin,
    output busy, done, s, cout, v, z
  );
endinterface

// File: rtl/mbledhesi_serik.sv
// Multi-cycle adder/subtractor: SLICE bits per clock through a registered ripple carry.
// Define MBLEDHESI_SAT_EN to saturate S on signed overflow instead of wrapping.
module mbledhesi_serik #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input logic           clk,
  input logic           rst_n,
  mbledhesi_serik_if.slave bus
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cout_q, cout_d;
  logic             v_q, v_d;
  logic             z_q, z_d;

  logic [SLICE-1:0] a_sl, b_sl, sum_sl;
  logic             c_msb, c_out;
  logic [WIDTH-1:0] s_fin;
  logic             v_fin;

  // One slice of full adders; c_msb is the carry entering the slice's top bit.
  always_comb begin
    logic c;
    a_sl   = a_q[cnt_q*SLICE +: SLICE];
    b_sl   = b_q[cnt_q*SLICE +: SLICE];
    sum_sl = '0;
    c      = carry_q;
    c_msb  = carry_q;
    for (int i = 0; i < SLICE; i++) begin
      if (i == SLICE - 1) c_msb = c;
      sum_sl[i] = a_sl[i] ^ b_sl[i] ^ c;
      c = (a_sl[i] & b_sl[i]) | (a_sl[i] & c) | (b_sl[i] & c);
    end
    c_out = c;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sh_d    = sh_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cout_d  = cout_q;
    v_d     = v_q;
    z_d     = z_q;
    s_fin   = sh_q;
    v_fin   = 1'b0;

    unique case (state_q)
      IDLE, FIN: begin
        busy_d  = 1'b0;
        state_d = IDLE;
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b ^ {WIDTH{bus.op}};
          carry_d = bus.op | bus.cin;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        sh_d[cnt_q*SLICE +: SLICE] = sum_sl;
        carry_d = c_out;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          // Results are published only here, so S never shows a partial sum.
          s_fin = sh_d;
          v_fin = c_msb ^ c_out;
`ifdef MBLEDHESI_SAT_EN
          if (v_fin) begin
            s_fin = (!a_q[WIDTH-1] && !b_q[WIDTH-1]) ? {1'b0, {(WIDTH-1){1'b1}}}
                                                     : {1'b1, {(WIDTH-1){1'b0}}};
          end
`endif
          s_d     = s_fin;
          cout_d  = c_out;
          v_d     = v_fin;
          z_d     = (s_fin == '0);
          done_d  = 1'b1;
          busy_d  = 1'b0;
          cnt_d   = '0;
          state_d = FIN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sh_q    <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sh_q    <= sh_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cout_q  <= cout_d;
      v_q     <= v_d;
      z_q     <= z_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.s    = s_q;
  assign bus.cout = cout_q;
  assign bus.v    = v_q;
  assign bus.z    = z_q;

endmodule

// File: tb/tb_mbledhesi_serik.sv
// Scoreboard bench for mbledhesi_serik: directed handshake/reset cases on SLICE=8,
// then random vectors across SLICE in {8,1,4,32}. Honours MBLEDHESI_SAT_EN.
module tb_mbledhesi_serik;

  localparam int WIDTH = 32;
  localparam int NCFG  = 4;

  function automatic int slOf(input int g);
    case (g)
      0:       return 8;
      1:       return 1;
      2:       return 4;
      default: return 32;
    endcase
  endfunction

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             v;
    logic             z;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start, op, cin;
  logic [WIDTH-1:0] a, b;
  logic [NCFG-1:0]  en;

  logic             busy_w [NCFG];
  logic             done_w [NCFG];
  logic             cout_w [NCFG];
  logic             v_w    [NCFG];
  logic             z_w    [NCFG];
  logic [WIDTH-1:0] s_w    [NCFG];

  exp_t sb [NCFG][$];
  int   done_cyc [NCFG] = '{default: -1};
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NCFG; g++) begin : cfg
    localparam int SL = (g == 0) ? 8 : (g == 1) ? 1 : (g == 2) ? 4 : 32;
    mbledhesi_serik_if #(.WIDTH(WIDTH)) bus ();
    assign bus.start = start & en[g];
    assign bus.op    = op;
    assign bus.a     = a;
    assign bus.b     = b;
    assign bus.cin   = cin;
    assign busy_w[g] = bus.busy;
    assign done_w[g] = bus.done;
    assign s_w[g]    = bus.s;
    assign cout_w[g] = bus.cout;
    assign v_w[g]    = bus.v;
    assign z_w[g]    = bus.z;
    mbledhesi_serik #(.WIDTH(WIDTH), .SLICE(SL)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );
  end

  // Reference written as one wide addition plus a (WIDTH-1)-bit addition for the MSB carry-in.
  function automatic exp_t model(input logic o, input logic [WIDTH-1:0] x,
                                 input logic [WIDTH-1:0] y, input logic ci);
    exp_t e;
    logic [WIDTH:0]   full;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] be;
    logic             c0;
    be   = o ? ~y : y;
    c0   = o ? 1'b1 : ci;
    full = {1'b0, x} + {1'b0, be} + {{WIDTH{1'b0}}, c0};
    lo   = {1'b0, x[WIDTH-2:0]} + {1'b0, be[WIDTH-2:0]} + {{(WIDTH-1){1'b0}}, c0};
    e.s    = full[WIDTH-1:0];
    e.cout = full[WIDTH];
    e.v    = lo[WIDTH-1] ^ full[WIDTH];
`ifdef MBLEDHESI_SAT_EN
    if (e.v) e.s = (!x[WIDTH-1] && !be[WIDTH-1]) ? {1'b0, {(WIDTH-1){1'b1}}}
                                                 : {1'b1, {(WIDTH-1){1'b0}}};
`endif
    e.z = (e.s == '0);
    return e;
  endfunction

  task automatic chkWord(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  task automatic chkBit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkInt(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input int g);
    exp_t e;
    chkBit($sformatf("done_expected[%0d]", g), (sb[g].size() != 0), 1'b1);
    if (sb[g].size() != 0) begin
      e = sb[g].pop_front();
      chkWord($sformatf("s[%0d]", g), s_w[g], e.s);
      chkBit($sformatf("cout[%0d]", g), cout_w[g], e.cout);
      chkBit($sformatf("v[%0d]", g), v_w[g], e.v);
      chkBit($sformatf("z[%0d]", g), z_w[g], e.z);
      chkBit($sformatf("busy_at_done[%0d]", g), busy_w[g], 1'b0);
    end
  endtask

  // Advance one clock and sample every instance on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cycle++;
    for (int g = 0; g < NCFG; g++) begin
      if (done_w[g] === 1'b1) begin
        done_cyc[g] = cycle;
        checkOutput(g);
      end
    end
  endtask

  function automatic bit allDone(input int since);
    for (int g = 0; g < NCFG; g++) begin
      if (en[g] && done_cyc[g] <= since) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic waitAll(input int since);
    int n = 0;
    while (!allDone(since) && n < 60) begin
      tick();
      n++;
    end
  endtask

  task automatic pushAll();
    for (int g = 0; g < NCFG; g++) begin
      if (en[g]) sb[g].push_back(model(op, a, b, cin));
    end
  endtask

  task automatic applyStimulus(input logic o, input logic [WIDTH-1:0] x,
                               input logic [WIDTH-1:0] y, input logic ci);
    int c0;
    op    = o;
    a     = x;
    b     = y;
    cin   = ci;
    start = 1'b1;
    pushAll();
    c0 = cycle;
    tick();
    start = 1'b0;
    waitAll(c0);
    for (int g = 0; g < NCFG; g++) begin
      if (en[g]) chkInt($sformatf("latency[%0d]", g), done_cyc[g] - c0, WIDTH / slOf(g) + 1);
    end
  endtask

  task automatic checkReset();
    chkBit("rst_busy", busy_w[0], 1'b0);
    chkBit("rst_done", done_w[0], 1'b0);
    chkWord("rst_s", s_w[0], '0);
    chkBit("rst_cout", cout_w[0], 1'b0);
    chkBit("rst_v", v_w[0], 1'b0);
    chkBit("rst_z", z_w[0], 1'b0);
  endtask

  initial begin
    int c0;
    int d1;
    logic ro, rc;
    logic [WIDTH-1:0] ra, rb;

    en    = 4'b0001;
    start = 1'b0;
    op    = 1'b0;
    cin   = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    checkReset();
    rst_n = 1'b1;
    tick();

    applyStimulus(1'b0, 32'h0000_00FF, 32'h0000_0001, 1'b0);
    applyStimulus(1'b1, 32'd5, 32'd7, 1'b0);
    applyStimulus(1'b1, 32'd7, 32'd5, 1'b1);
    applyStimulus(1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    applyStimulus(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    applyStimulus(1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0);

    // New operands offered while busy must not disturb the first request.
    op = 1'b0; a = 32'd1; b = 32'd2; cin = 1'b0; start = 1'b1;
    pushAll();
    c0 = cycle;
    tick();
    op = 1'b1; a = 32'd100; b = 32'd200;
    tick();
    chkBit("busy_while_run", busy_w[0], 1'b1);
    tick();
    start = 1'b0;
    waitAll(c0);
    chkInt("busy_ignore_latency", done_cyc[0] - c0, 5);
    d1 = done_cyc[0];
    repeat (6) tick();
    chkInt("busy_ignore_no_extra_done", done_cyc[0], d1);

    // Back-to-back: START held in the DONE cycle.
    op = 1'b0; a = 32'd10; b = 32'd20; cin = 1'b0; start = 1'b1;
    pushAll();
    c0 = cycle;
    tick();
    start = 1'b0;
    waitAll(c0);
    chkBit("fin_done", done_w[0], 1'b1);
    d1 = done_cyc[0];
    op = 1'b1; a = 32'd50; b = 32'd8; start = 1'b1;
    pushAll();
    tick();
    start = 1'b0;
    waitAll(d1);
    chkInt("b2b_gap", done_cyc[0] - d1, 5);

    // Reset in the second RUN cycle aborts the operation.
    op = 1'b0; a = 32'd123; b = 32'd456; start = 1'b1;
    c0 = cycle;
    tick();
    start = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    checkReset();
    sb[0].delete();
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (8) tick();
    chkInt("no_done_after_reset", (done_cyc[0] > c0) ? 1 : 0, 0);
    applyStimulus(1'b0, 32'h1234_5678, 32'h1111_1111, 1'b1);

    en = 4'b1111;
    applyStimulus(1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    applyStimulus(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    applyStimulus(1'b1, 32'd5, 32'd7, 1'b0);
    for (int i = 0; i < 1000; i++) begin
      ro = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = $urandom;
      applyStimulus(ro, ra, rb, rc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
